// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one command byte to a PS/2 device. The host holds the clock line low
// to inhibit the bus, then issues a request-to-send. The device then clocks
// the frame out: data LSB first, odd parity, stop. The host releases the data
// line and samples the device acknowledge.
//
// Parameters
//   INHIBIT_CYC  clk cycles PS2C_lo is held high before request-to-send (>= 2)
//   TIMEOUT_CYC  watchdog limit in clk cycles (used only with the macro below)
//
// Optional feature
//   `define PS2_HOST_TX_TIMEOUT_EN  enables a watchdog that aborts a transfer
//   when the device stops clocking. If it is not defined, the block waits for
//   device clocks with no time limit.
//
// Ports
//   clk      system clock, all logic on posedge
//   rst      asynchronous, active-low reset
//   start    one-cycle send request, accepted only while rdy=1
//   data     command byte, captured on the accepted start
//   PS2C_in  sampled PS/2 clock line
//   PS2D_in  sampled PS/2 data line
//   PS2C_lo  1 = drive PS/2 clock low, 0 = release
//   PS2D_lo  1 = drive PS/2 data low, 0 = release
//   rdy      1 = idle, a new start is accepted
//   done     one-cycle pulse at the end of every transfer
//   err      1 = last transfer had no acknowledge or timed out
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 3750,
  parameter int TIMEOUT_CYC = 562500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       PS2C_in,
  input  logic       PS2D_in,
  output logic       PS2C_lo,
  output logic       PS2D_lo,
  output logic       rdy,
  output logic       done,
  output logic       err
);

  localparam int INH_W = (INHIBIT_CYC > 2) ? $clog2(INHIBIT_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    RELEASE
  } state_t;

  state_t           state_reg;
  logic             c_meta_reg, c_sync_reg, c_prev_reg;
  logic             d_meta_reg, d_sync_reg;
  logic [9:0]       shift_reg;
  logic [3:0]       bit_cnt_reg;
  logic [INH_W-1:0] inh_cnt_reg;
  logic             fe;

  // The bus idles high, so the synchronizer resets to 1. This keeps reset
  // release from looking like a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_meta_reg <= 1'b1;
      c_sync_reg <= 1'b1;
      c_prev_reg <= 1'b1;
      d_meta_reg <= 1'b1;
      d_sync_reg <= 1'b1;
    end else begin
      c_meta_reg <= PS2C_in;
      c_sync_reg <= c_meta_reg;
      c_prev_reg <= c_sync_reg;
      d_meta_reg <= PS2D_in;
      d_sync_reg <= d_meta_reg;
    end
  end

  assign fe = c_prev_reg & ~c_sync_reg;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WD_W-1:0] wd_cnt_reg;
  logic            wd_active;
  logic            wd_expired;

  assign wd_active  = (state_reg == REQ) || (state_reg == SHIFT) || (state_reg == ACK);
  assign wd_expired = wd_active && (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1));

  // The counter is held at 0 outside REQ/SHIFT/ACK. That clears it on entry
  // to REQ. Each device clock edge restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_reg <= '0;
    end else if (!wd_active || fe) begin
      wd_cnt_reg <= '0;
    end else if (!wd_expired) begin
      wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      inh_cnt_reg <= '0;
      PS2C_lo     <= 1'b0;
      PS2D_lo     <= 1'b0;
      rdy         <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          PS2C_lo <= 1'b0;
          PS2D_lo <= 1'b0;
          if (start) begin
            // Frame: stop bit at the MSB, odd parity, then the data byte.
            shift_reg   <= {1'b1, ~^data, data};
            err         <= 1'b0;
            rdy         <= 1'b0;
            inh_cnt_reg <= '0;
            PS2C_lo     <= 1'b1;
            state_reg   <= INHIBIT;
          end
        end

        INHIBIT: begin
          // Pull data low one cycle before releasing clock. Clock and data
          // then change on different cycles.
          if (inh_cnt_reg == INH_W'(INHIBIT_CYC - 2)) begin
            PS2D_lo <= 1'b1;
          end
          if (inh_cnt_reg == INH_W'(INHIBIT_CYC - 1)) begin
            PS2C_lo   <= 1'b0;
            state_reg <= REQ;
          end else begin
            inh_cnt_reg <= inh_cnt_reg + INH_W'(1);
          end
        end

        REQ: begin
          if (fe) begin
            PS2D_lo     <= ~shift_reg[0];
            shift_reg   <= {1'b0, shift_reg[9:1]};
            bit_cnt_reg <= '0;
            state_reg   <= SHIFT;
          end
        end

        SHIFT: begin
          if (fe) begin
            if (bit_cnt_reg == 4'd9) begin
              // Stop bit was on the line. Release data for the acknowledge.
              PS2D_lo   <= 1'b0;
              state_reg <= ACK;
            end else begin
              PS2D_lo     <= ~shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[9:1]};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
          end
        end

        ACK: begin
          if (fe) begin
            err       <= d_sync_reg;
            state_reg <= RELEASE;
          end
        end

        RELEASE: begin
          PS2C_lo <= 1'b0;
          PS2D_lo <= 1'b0;
          if (c_sync_reg && d_sync_reg) begin
            done      <= 1'b1;
            rdy       <= 1'b1;
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
      // The watchdog takes priority over any fe seen in the same cycle.
      if (wd_expired) begin
        PS2C_lo   <= 1'b0;
        PS2D_lo   <= 1'b0;
        err       <= 1'b1;
        state_reg <= RELEASE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- self-checking bench for ps2_host_tx.
// A behavioural PS/2 device shares open-collector lines with the DUT. It
// waits for the request-to-send and produces falling clock edges. It reads
// each frame bit while the clock is low, then optionally acknowledges. The
// expected frame is built from the byte with plain arithmetic: start 0, data
// LSB first, odd parity, stop 1.
module tb_ps2_host_tx;

  localparam int INH  = 3750;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       dev_clk_lo = 1'b0;
  logic       dev_data_lo = 1'b0;
  logic       ps2c, ps2d;
  logic       PS2C_lo, PS2D_lo, rdy, done, err;

  assign ps2c = ~(PS2C_lo | dev_clk_lo);
  assign ps2d = ~(PS2D_lo | dev_data_lo);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .data   (data),
    .PS2C_in(ps2c),
    .PS2D_in(ps2d),
    .PS2C_lo(PS2C_lo),
    .PS2D_lo(PS2D_lo),
    .rdy    (rdy),
    .done   (done),
    .err    (err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor: length of each PS2C_lo=1 run, data drive at its first and last
  // cycle, and done pulse count and width.
  int   run_len = 0, inh_len = 0, done_cnt = 0, done_wide = 0;
  logic cur_first_d = 1'b0, inh_first_d = 1'b0, inh_last_d = 1'b0, done_prev = 1'b0;

  always @(negedge clk) begin
    if (PS2C_lo) begin
      if (run_len == 0) cur_first_d <= PS2D_lo;
      run_len    <= run_len + 1;
      inh_last_d <= PS2D_lo;
    end else if (run_len != 0) begin
      inh_len     <= run_len;
      inh_first_d <= cur_first_d;
      run_len     <= 0;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (done && done_prev) done_wide <= done_wide + 1;
    done_prev <= done;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // abort_fe>0 asserts reset after that falling edge. poke pulses start with
  // other data in the middle of the frame.
  task automatic xfer(input logic [7:0] d, input bit ack, input int abort_fe, input bit poke);
    logic [10:0] frame, exp_frame;
    logic        rel, par;
    int          n, dc0, ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par = ((ones % 2) == 0);
    exp_frame = {1'b1, par, d, 1'b0};
    frame = '0;
    rel = 1'b0;
    n = 0;
    while (!rdy && n < 200) begin tick; n++; end
    check_eq("rdy_before", rdy, 1);
    dc0 = done_cnt;
    data = d; start = 1'b1;
    tick;
    start = 1'b0; data = ~d;
    check_eq("rdy_busy", rdy, 0);
    check_eq("err_cleared", err, 0);
    n = 0;
    while (PS2C_lo && n < INH + 100) begin tick; n++; end
    check_eq("inhibit_end", PS2C_lo, 0);
    repeat (HALF) tick;
    check_eq("inhibit_len", inh_len, INH);
    check_eq("inhibit_first_d", inh_first_d, 0);
    check_eq("inhibit_last_d", inh_last_d, 1);
    frame[0] = ps2d;
    for (int k = 1; k <= 12; k++) begin
      dev_clk_lo = 1'b1;
      repeat (HALF) tick;
      if (k == abort_fe) begin
        rst = 1'b0;
        #1;
        check_eq("abort_clk_rel", PS2C_lo, 0);
        check_eq("abort_dat_rel", PS2D_lo, 0);
        check_eq("abort_rdy", rdy, 1);
        check_eq("abort_done", done, 0);
        dev_clk_lo = 1'b0; dev_data_lo = 1'b0;
        tick; tick;
        rst = 1'b1;
        repeat (50) tick;
        check_eq("abort_no_done", done_cnt - dc0, 0);
        $display("xfer data=%02h aborted after fe %0d", d, k);
        return;
      end
      dev_clk_lo = 1'b0;
      if (k <= 10) frame[k] = ps2d;
      if (k == 11) begin
        rel = ps2d;
        if (ack) dev_data_lo = 1'b1;
      end
      if (k == 3 && poke) begin
        data = 8'($urandom); start = 1'b1;
        tick;
        start = 1'b0;
      end
      repeat (HALF) tick;
    end
    dev_data_lo = 1'b0;
    n = 0;
    while (done_cnt == dc0 && n < 200) begin tick; n++; end
    check_eq("done_seen", done_cnt - dc0, 1);
    check_eq("frame", frame, exp_frame);
    check_eq("ack_release", rel, 1);
    check_eq("err", err, ack ? 0 : 1);
    check_eq("rdy_after", rdy, 1);
    $display("xfer data=%02h ack=%0d poke=%0d frame=%03h expected=%03h err=%0d",
             d, ack, poke, frame, exp_frame, err);
  endtask

  task automatic no_clock_test;
    int n, dc0;
    dc0 = done_cnt;
    data = 8'h5A; start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (PS2C_lo && n < INH + 100) begin tick; n++; end
`ifdef PS2_HOST_TX_TIMEOUT_EN
    n = 0;
    while (done_cnt == dc0 && n < TO + 200) begin tick; n++; end
    check_eq("to_done", done_cnt - dc0, 1);
    check_eq("to_err", err, 1);
    check_eq("to_clk_rel", PS2C_lo, 0);
    check_eq("to_dat_rel", PS2D_lo, 0);
    check_eq("to_rdy", rdy, 1);
    $display("timeout xfer done=%0d err=%0d", done_cnt - dc0, err);
`else
    repeat (TO + 1000) tick;
    check_eq("wait_rdy_low", rdy, 0);
    check_eq("wait_no_done", done_cnt - dc0, 0);
    $display("no-clock xfer rdy=%0d (waiting)", rdy);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    tick;
`endif
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) tick;
    check_eq("rst_rdy", rdy, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_clk_lo", PS2C_lo, 0);
    check_eq("rst_dat_lo", PS2D_lo, 0);
    rst = 1'b1;
    repeat (5) tick;

    xfer(8'hED, 1'b1, 0, 1'b0);
    xfer(8'h00, 1'b1, 0, 1'b0);
    xfer(8'hA5, 1'b0, 0, 1'b0);
    xfer(8'hFF, 1'b1, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      xfer(8'($urandom), bit'($urandom_range(0, 1)), 0, bit'(i % 2));
    end
    xfer(8'h3C, 1'b1, 4, 1'b0);
    xfer(8'hF4, 1'b1, 0, 1'b0);
    no_clock_test();
    xfer(8'h81, 1'b1, 0, 1'b0);
    check_eq("done_width", done_wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
